// File: rtl/branch_resolve_queue.sv
// Purpose: FIFO of outstanding branch predictions; resolves the oldest against its actual outcome and emits a BHT update.
// Latency: update strobe (upd_*/mispredict) and hit/miss counters are registered one edge after the pop.
// Backpressure: pred_ready drops when full (no same-cycle pop bypass); res_ready drops when empty; flush wins over push/pop.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       res_ready,
  input  logic                       flush,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0]   STAT_MAX = 16'hFFFF;

  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_d [DEPTH];
  logic            tk_mem_q [DEPTH];
  logic            tk_mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic            upd_valid_q, upd_valid_d;
  logic [PC_W-1:0] upd_pc_q, upd_pc_d;
  logic            upd_taken_q, upd_taken_d;
  logic            mispredict_q, mispredict_d;
  logic [15:0]     hit_q, hit_d;
  logic [15:0]     miss_q, miss_d;
  logic            push, pop, wrong;

  // Handshakes derive only from registered occupancy, so a full queue refuses a push even when a pop is in progress.
  assign pred_ready = (occ_q != CNT_FULL);
  assign res_ready  = (occ_q != '0);
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && res_ready;
  assign wrong      = tk_mem_q[rd_ptr_q] != res_taken;

  assign occupancy  = occ_q;
  assign upd_valid  = upd_valid_q;
  assign upd_pc     = upd_pc_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mispredict_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Next-state: flush clears the queue and suppresses any same-cycle update; otherwise push/pop with saturating stats.
  always_comb begin
    pc_mem_d     = pc_mem_q;
    tk_mem_d     = tk_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    upd_valid_d  = 1'b0;
    upd_pc_d     = upd_pc_q;
    upd_taken_d  = upd_taken_q;
    mispredict_d = 1'b0;
    hit_d        = hit_q;
    miss_d       = miss_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q] = pred_pc;
        tk_mem_d[wr_ptr_q] = pred_taken;
        wr_ptr_d           = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
        upd_valid_d  = 1'b1;
        upd_pc_d     = pc_mem_q[rd_ptr_q];
        upd_taken_d  = res_taken;
        mispredict_d = wrong;
        if (wrong) begin
          if (miss_q != STAT_MAX) miss_d = miss_q + 16'd1;
        end else begin
          if (hit_q != STAT_MAX) hit_d = hit_q + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + CNT_ONE;
        2'b01:   occ_d = occ_q - CNT_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset overriding flush, push and pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i] <= '0;
        tk_mem_q[i] <= 1'b0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      pc_mem_q     <= pc_mem_d;
      tk_mem_q     <= tk_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH=4, PC_W=9).
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants.
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       pred_valid;
  logic [8:0] pred_pc;
  logic       pred_taken;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;
  logic       flush;
  logic       upd_valid;
  logic [8:0] upd_pc;
  logic       upd_taken;
  logic       mispredict;
  logic [2:0] occupancy;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_assert = 0;
  int n_fail   = 0;

  branch_resolve_queue #(.DEPTH(4), .PC_W(9)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .mispredict(mispredict),
    .occupancy(occupancy), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_only(input logic [8:0] pc, input logic tk);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; res_valid = 1'b0;
  endtask

  task automatic idle();
    pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0;
    #1;
    tick(); tick();
    reset = 1'b1;
    chk("rst_occ",   32'(occupancy),  0);
    chk("rst_prdy",  32'(pred_ready), 1);
    chk("rst_rrdy",  32'(res_ready),  0);
    chk("rst_uv",    32'(upd_valid),  0);
    chk("rst_upc",   32'(upd_pc),     0);
    chk("rst_hit",   32'(hit_count),  0);
    chk("rst_miss",  32'(miss_count), 0);

    // Basic resolve: (0x012,T),(0x034,N), both resolve taken.
    push_only(9'h012, 1'b1); tick();
    push_only(9'h034, 1'b0); tick();
    pred_valid = 1'b0;
    chk("b_occ2", 32'(occupancy), 2);
    res_valid = 1'b1; res_taken = 1'b1; tick();
    chk("b1_uv",   32'(upd_valid),  1);
    chk("b1_upc",  32'(upd_pc),     32'h012);
    chk("b1_utk",  32'(upd_taken),  1);
    chk("b1_misp", 32'(mispredict), 0);
    chk("b1_hit",  32'(hit_count),  1);
    tick();
    chk("b2_uv",   32'(upd_valid),  1);
    chk("b2_upc",  32'(upd_pc),     32'h034);
    chk("b2_misp", 32'(mispredict), 1);
    chk("b2_hit",  32'(hit_count),  1);
    chk("b2_miss", 32'(miss_count), 1);
    chk("b2_occ",  32'(occupancy),  0);
    // res_valid held on empty queue: ignored.
    tick();
    chk("e_uv",   32'(upd_valid),  0);
    chk("e_misp", 32'(mispredict), 0);
    chk("e_upc",  32'(upd_pc),     32'h034);
    chk("e_utk",  32'(upd_taken),  1);
    chk("e_hit",  32'(hit_count),  1);
    chk("e_miss", 32'(miss_count), 1);
    res_valid = 1'b0;

    // Fill: five pushes into a 4-deep queue.
    push_only(9'h100, 1'b0); tick();
    push_only(9'h101, 1'b1); tick();
    push_only(9'h102, 1'b0); tick();
    chk("f3_prdy", 32'(pred_ready), 1);
    push_only(9'h103, 1'b1); tick();
    chk("f4_prdy", 32'(pred_ready), 0);
    chk("f4_occ",  32'(occupancy),  4);
    push_only(9'h104, 1'b0); tick();
    chk("f5_occ",  32'(occupancy),  4);
    // Push + pop while full: push refused, occupancy drops.
    pred_valid = 1'b1; pred_pc = 9'h1FF; pred_taken = 1'b1;
    res_valid = 1'b1; res_taken = 1'b0; tick();
    chk("fp_occ",  32'(occupancy),  3);
    chk("fp_upc",  32'(upd_pc),     32'h100);
    chk("fp_misp", 32'(mispredict), 0);
    chk("fp_hit",  32'(hit_count),  2);
    chk("fp_prdy", 32'(pred_ready), 1);
    pred_valid = 1'b0; res_taken = 1'b1; tick();
    chk("d1_upc",  32'(upd_pc),     32'h101);
    chk("d1_hit",  32'(hit_count),  3);
    tick();
    chk("d2_upc",  32'(upd_pc),     32'h102);
    chk("d2_misp", 32'(mispredict), 1);
    chk("d2_miss", 32'(miss_count), 2);
    tick();
    chk("d3_upc",  32'(upd_pc),     32'h103);
    chk("d3_hit",  32'(hit_count),  4);
    chk("d3_occ",  32'(occupancy),  0);
    chk("d3_rrdy", 32'(res_ready),  0);
    res_valid = 1'b0;

    // Simultaneous push+pop at occupancy 1 across pointer wrap.
    push_only(9'h055, 1'b1); tick();
    chk("w0_occ", 32'(occupancy), 1);
    pred_valid = 1'b1; pred_pc = 9'h066; pred_taken = 1'b0;
    res_valid = 1'b1; res_taken = 1'b1; tick();
    chk("w1_occ",  32'(occupancy),  1);
    chk("w1_upc",  32'(upd_pc),     32'h055);
    chk("w1_hit",  32'(hit_count),  5);
    pred_pc = 9'h077; pred_taken = 1'b1; tick();
    chk("w2_occ",  32'(occupancy),  1);
    chk("w2_upc",  32'(upd_pc),     32'h066);
    chk("w2_misp", 32'(mispredict), 1);
    chk("w2_miss", 32'(miss_count), 3);
    pred_valid = 1'b0; res_taken = 1'b0; tick();
    chk("w3_upc",  32'(upd_pc),     32'h077);
    chk("w3_miss", 32'(miss_count), 4);
    chk("w3_occ",  32'(occupancy),  0);

    // Flush with 3 entries while push and res_valid are asserted.
    push_only(9'h0A1, 1'b1); tick();
    push_only(9'h0A2, 1'b0); tick();
    push_only(9'h0A3, 1'b1); tick();
    chk("fl_occ3", 32'(occupancy), 3);
    pred_pc = 9'h0A4; res_valid = 1'b1; res_taken = 1'b0; flush = 1'b1; tick();
    chk("fl_occ",  32'(occupancy),  0);
    chk("fl_uv",   32'(upd_valid),  0);
    chk("fl_hit",  32'(hit_count),  5);
    chk("fl_miss", 32'(miss_count), 4);
    chk("fl_rrdy", 32'(res_ready),  0);
    idle();
    // A registered strobe survives a flush raised in its cycle.
    push_only(9'h0B0, 1'b1); tick();
    pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1; tick();
    res_valid = 1'b0; flush = 1'b1; #1;
    chk("fs_uv",  32'(upd_valid), 1);
    chk("fs_upc", 32'(upd_pc),    32'h0B0);
    tick();
    flush = 1'b0;
    chk("fs_hit", 32'(hit_count), 6);

    // miss_count saturation.
    force dut.miss_q = 16'hFFFE;
    #1;
    release dut.miss_q;
    push_only(9'h0C0, 1'b1); tick();
    pred_pc = 9'h0C1; pred_taken = 1'b1; res_valid = 1'b1; res_taken = 1'b0; tick();
    chk("s1_miss", 32'(miss_count), 32'hFFFF);
    chk("s1_upc",  32'(upd_pc),     32'h0C0);
    pred_valid = 1'b0; tick();
    chk("s2_miss", 32'(miss_count), 32'hFFFF);
    chk("s2_misp", 32'(mispredict), 1);
    chk("s2_hit",  32'(hit_count),  6);
    res_valid = 1'b0;

    // Reset mid-stream with 2 entries and a pop presented.
    push_only(9'h0D0, 1'b1); tick();
    push_only(9'h0D1, 1'b0); tick();
    pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b0; reset = 1'b0; tick();
    chk("r_uv",   32'(upd_valid),  0);
    chk("r_upc",  32'(upd_pc),     0);
    chk("r_utk",  32'(upd_taken),  0);
    chk("r_misp", 32'(mispredict), 0);
    chk("r_hit",  32'(hit_count),  0);
    chk("r_miss", 32'(miss_count), 0);
    chk("r_occ",  32'(occupancy),  0);
    chk("r_prdy", 32'(pred_ready), 1);
    chk("r_rrdy", 32'(res_ready),  0);
    reset = 1'b1; tick();
    chk("r2_uv",  32'(upd_valid),  0);
    chk("r2_occ", 32'(occupancy),  0);
    res_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
